// File: rtl/mem_arbiter_if.sv
// Byte-wide RAM port bundle shared by the IF and MEM requesters.
// The slave modport faces the arbiter; the master modport faces the
// requesters and the RAM. The io_buffer_full signal exists only when
// IO_BUFFER_FULL_EN is defined.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
`ifdef IO_BUFFER_FULL_EN
  logic              io_buffer_full;
`endif

  modport slave (
`ifdef IO_BUFFER_FULL_EN
    input  io_buffer_full,
`endif
    input  if_req, if_addr, if_flush,
    output if_done, if_data,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_done, mem_rdata,
    input  ram_din,
    output ram_a, ram_dout, ram_wr
  );

  modport master (
`ifdef IO_BUFFER_FULL_EN
    output io_buffer_full,
`endif
    output if_req, if_addr, if_flush,
    input  if_done, if_data,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_done, mem_rdata,
    output ram_din,
    input  ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM/IO port between instruction fetch
// (IF) and memory access (MEM). Requests of 1/2/4 bytes are split into
// per-byte RAM cycles; read bytes are assembled little-endian and each
// requester gets a one-cycle done pulse. MEM has fixed priority, IF
// fetches can be aborted by if_flush.
// Optional: define IO_BUFFER_FULL_EN to stall stores to the IO window
// (address bits [17:16] == 2'b11) while io_buffer_full is high.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IF_RD  = 2'd1;
  localparam logic [1:0] S_MEM_RD = 2'd2;
  localparam logic [1:0] S_MEM_WR = 2'd3;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [2:0]        len;
  logic [2:0]        mem_len;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       rd_next;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [7:0]        hold_q;
  logic              hold_v;
  logic [7:0]        cap_byte;
  logic [7:0]        dout;
  logic              wr_q;
  logic              stall;
  logic              rd_state;

  assign rd_state = (state == S_IF_RD) || (state == S_MEM_RD);
  assign wr_q     = (state == S_MEM_WR);

`ifdef IO_BUFFER_FULL_EN
  assign stall = wr_q && (base[17:16] == 2'b11) && bus.io_buffer_full;
`else
  assign stall = 1'b0;
`endif

  // Byte count of a MEM request; size 3 behaves as a word.
  always_comb begin
    case (bus.mem_size)
      2'd0:    mem_len = 3'd1;
      2'd1:    mem_len = 3'd2;
      default: mem_len = 3'd4;
    endcase
  end

  // The RAM keeps answering while rdy is low, but ram_a stays parked on the
  // next address, so the byte owed to the transfer is only on ram_din during
  // the first frozen cycle. hold_q keeps it for the resuming edge.
  assign cap_byte = hold_v ? hold_q : bus.ram_din;

  // Read buffer with the byte returned for address cnt-1 merged in.
  always_comb begin
    rd_next = buf_q;
    case (cnt)
      3'd1:    rd_next[7:0]   = cap_byte;
      3'd2:    rd_next[15:8]  = cap_byte;
      3'd3:    rd_next[23:16] = cap_byte;
      3'd4:    rd_next[31:24] = cap_byte;
      default: ;
    endcase
  end

  // Store byte for the current counter position.
  always_comb begin
    case (cnt)
      3'd0:    dout = wdata_q[7:0];
      3'd1:    dout = wdata_q[15:8];
      3'd2:    dout = wdata_q[23:16];
      3'd3:    dout = wdata_q[31:24];
      default: dout = 8'h00;
    endcase
  end

  // Arbitration, byte sequencing, read assembly and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      len         <= '0;
      base        <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      hold_q      <= '0;
      hold_v      <= 1'b0;
    end else if (!rdy) begin
      if (rd_state && !hold_v) begin
        hold_q <= bus.ram_din;
        hold_v <= 1'b1;
      end
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      hold_v     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!if_done_q && !mem_done_q) begin
            if (bus.mem_req) begin
              state   <= bus.mem_we ? S_MEM_WR : S_MEM_RD;
              base    <= bus.mem_addr;
              len     <= mem_len;
              wdata_q <= bus.mem_wdata;
              cnt     <= '0;
              buf_q   <= '0;
            end else if (bus.if_req && !bus.if_flush) begin
              state <= S_IF_RD;
              base  <= bus.if_addr;
              len   <= 3'd4;
              cnt   <= '0;
              buf_q <= '0;
            end
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if ((state == S_IF_RD) && bus.if_flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            buf_q <= rd_next;
            if (cnt == len) begin
              state <= S_IDLE;
              cnt   <= '0;
              if (state == S_IF_RD) begin
                if_data_q <= rd_next;
                if_done_q <= 1'b1;
              end else begin
                mem_rdata_q <= rd_next;
                mem_done_q  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        S_MEM_WR: begin
          if (!stall) begin
            if (cnt == len - 3'd1) begin
              state      <= S_IDLE;
              cnt        <= '0;
              mem_done_q <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_a     = base + ADDR_W'(cnt);
  assign bus.ram_dout  = dout;
  assign bus.ram_wr    = wr_q & rdy & ~stall;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized IF/MEM traffic, checked cycle by cycle against a transaction
// level model (byte address sequence, done latency, little-endian data)
// and a reference memory image.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic io_full = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

`ifdef IO_BUFFER_FULL_EN
  assign bus.io_buffer_full = io_full;
`endif

  int total = 0;
  int passed = 0;

  logic [7:0] ram [0:65535];
  bit         wvalid [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] din_q = 8'h00;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h13;
      16'h0101: return 8'h05;
      16'h0102: return 8'h00;
      16'h0103: return 8'h00;
      16'h1002: return 8'hEF;
      16'h1003: return 8'hBE;
      default:  return 8'(a * 16'd37) ^ a[15:8];
    endcase
  endfunction

  function automatic logic [7:0] env_byte(input logic [15:0] a);
    return wvalid[a] ? ram[a] : init_byte(a);
  endfunction

  // Byte-wide RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    din_q <= env_byte(bus.ram_a[15:0]);
    if (bus.ram_wr) begin
      ram[bus.ram_a[15:0]]    <= bus.ram_dout;
      wvalid[bus.ram_a[15:0]] <= 1'b1;
    end
  end
  assign bus.ram_din = din_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction from request to the no-grant edge after done.
  // rs/rl: rdy low for cycles rs..rs+rl-1 (rs=0: none).
  // fs/fl: io_full high for cycles fs..fs+fl-1 (fl=0: none).
  task automatic xfer(input bit is_if, input bit we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int rs, input int rl, input int fs, input int fl);
    int n;
    int adv;
    bit fin;
    bit step;
    bit io_st;
    logic [31:0] exp_d;
    n = is_if ? 4 : ((size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4));
    exp_d = '0;
    for (int i = 0; i < n; i++) exp_d[8*i +: 8] = ref_mem[16'(addr + 32'(i))];
    if (is_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_size  = size;
      bus.mem_addr  = addr;
      bus.mem_wdata = wd;
    end
    @(posedge clk);
    adv = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      #1;
      rdy     = !(rs != 0 && cyc >= rs && cyc < rs + rl);
      io_full = (fl != 0 && cyc >= fs && cyc < fs + fl);
      io_st   = we && !is_if && (addr[17:16] == 2'b11) && io_full;
      #1;
      if (adv < n) chk("ram_a", bus.ram_a, addr + 32'(adv));
      if (we && adv < n) chk("ram_dout", 32'(bus.ram_dout), 32'(wd[8*adv +: 8]));
      chk("ram_wr", 32'(bus.ram_wr), 32'(we && adv < n && rdy && !io_st));
      fin = we ? (adv == n) : (adv == n + 1);
      chk("if_done", 32'(bus.if_done), 32'(fin && is_if));
      chk("mem_done", 32'(bus.mem_done), 32'(fin && !is_if));
      if (fin && !we) begin
        if (is_if) chk("if_data", bus.if_data, exp_d);
        else       chk("mem_rdata", bus.mem_rdata, exp_d);
      end
      if (!fin) begin
        step = rdy && !io_st;
        @(posedge clk);
        if (step) adv++;
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    // Request is still held across the done cycle; that edge must not grant.
    @(posedge clk);
    #1;
    if (is_if) bus.if_req = 1'b0;
    else       bus.mem_req = 1'b0;
    chk("no_regrant_wr", 32'(bus.ram_wr), 32'd0);
    if (we) for (int i = 0; i < n; i++) ref_mem[16'(addr + 32'(i))] = wd[8*i +: 8];
  endtask

  initial begin
    int mism;
    int kind;
    int n;
    int rs;
    int rl;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0] sz;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    // Reset state.
    #1;
    chk("rst_ram_a", bus.ram_a, 32'd0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
    chk("rst_if_done", 32'(bus.if_done), 32'd0);
    chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Word fetch at 0x100 -> 0x00000513.
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0100, '0, 0, 0, 0, 0);
    chk("fetch_0x100", bus.if_data, 32'h0000_0513);

    // Simultaneous MEM half load and IF fetch: MEM first, then IF.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
    xfer(1'b0, 1'b0, 2'd1, 32'h0000_1002, '0, 0, 0, 0, 0);
    chk("half_0x1002", bus.mem_rdata, 32'h0000_BEEF);
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0200, '0, 0, 0, 0, 0);

    // Store word then byte load of its top byte.
    xfer(1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'h1122_3344, 0, 0, 0, 0);
    xfer(1'b0, 1'b0, 2'd0, 32'h0000_2003, '0, 0, 0, 0, 0);
    chk("byte_0x2003", bus.mem_rdata, 32'h0000_0011);

    // Flush in cycle 3 of a fetch: no if_done, then a normal fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    bus.if_flush = 1'b1;
    @(posedge clk); #1;
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flushed_no_done", 32'(bus.if_done), 32'd0);
      @(posedge clk); #1;
    end
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0100, '0, 0, 0, 0, 0);

    // Flush coinciding with an IDLE IF request suppresses that grant.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400; bus.if_flush = 1'b1;
    @(posedge clk); #1;
    bus.if_flush = 1'b0;
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0400, '0, 0, 0, 0, 0);

    // Flush does not block or disturb a MEM load.
    bus.if_flush = 1'b1;
    xfer(1'b0, 1'b0, 2'd3, 32'h0000_0500, '0, 0, 0, 0, 0);
    bus.if_flush = 1'b0;

    // rdy low for 3 cycles mid-read; word fetch wrapping past 2^32.
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0100, '0, 3, 3, 0, 0);
    xfer(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, '0, 2, 3, 0, 0);
    xfer(1'b0, 1'b1, 2'd1, 32'h0000_0600, 32'h0000_CAFE, 2, 2, 0, 0);

    // Async reset in cycle 3 of a word store: bytes 0 and 1 already written.
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'd2;
    bus.mem_addr = 32'h0000_2100; bus.mem_wdata = 32'hA1B2_C3D4;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("arst_ram_a", bus.ram_a, 32'd0);
    chk("arst_ram_dout", 32'(bus.ram_dout), 32'd0);
    chk("arst_mem_done", 32'(bus.mem_done), 32'd0);
    chk("arst_if_data", bus.if_data, 32'd0);
    chk("arst_mem_rdata", bus.mem_rdata, 32'd0);
    ref_mem[16'h2100] = 8'hD4;
    ref_mem[16'h2101] = 8'hC3;
    bus.mem_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", 32'(bus.mem_done), 32'd0);
    end
    xfer(1'b0, 1'b0, 2'd2, 32'h0000_2100, '0, 0, 0, 0, 0);

`ifdef IO_BUFFER_FULL_EN
    // IO byte store held off for 4 cycles by io_buffer_full.
    xfer(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A, 0, 0, 1, 4);
    io_full = 1'b0;
`endif

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      a    = {16'h0000, 16'($urandom)};
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      n    = (kind == 0) ? 4 : ((sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4));
      rs   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : 0;
      rl   = int'($urandom_range(1, 3));
      xfer(kind == 0, kind == 2, sz, a, wd, rs, rl, 0, 0);
    end

    // RAM image written through the DUT must match the reference image.
    mism = 0;
    for (int i = 0; i < 65536; i++)
      if (env_byte(16'(i)) !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
